// File: rtl/ultra_cpu_core.sv
// Multi-cycle accumulator CPU with internal program memory, Z/C flags,
// output latch and a run/halt handshake.
module ultra_cpu_core #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              run,
  output logic [DATA_W-1:0] acc_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic              zero_flag,
  output logic              carry_flag,
  output logic              busy,
  output logic              halted
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_IMM, S_EXEC, S_HALT
  } state_t;

  localparam logic [3:0] OP_LDI = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3,
                         OP_AND = 4'h4, OP_OR  = 4'h5, OP_XOR = 4'h6,
                         OP_NOT = 4'h7, OP_LDB = 4'h8, OP_STA = 4'h9,
                         OP_LDA = 4'hA, OP_JMP = 4'hB, OP_BEQ = 4'hC,
                         OP_BCS = 4'hD, OP_OUT = 4'hE, OP_HLT = 4'hF;

  state_t              state, state_nx;
  logic [DATA_W-1:0]   mem [2**ADDR_W];
  logic [DATA_W-1:0]   acc, b, ir, acc_nx;
  logic [ADDR_W-1:0]   pc;
  logic                zf, cf, acc_wr, stopped, start, load_ok;
  logic [DATA_W:0]     sum, diff;
  logic [3:0]          op;
  logic [ADDR_W-1:0]   addr;

  assign op      = ir[DATA_W-1:DATA_W-4];
  assign addr    = ir[ADDR_W-1:0];
  assign stopped = (state == S_IDLE) || (state == S_HALT);
  // A load in the same cycle as run wins; run is dropped.
  assign load_ok = stopped && load_en;
  assign start   = stopped && run && !load_en;

  assign sum  = {1'b0, acc} + {1'b0, b};
  assign diff = {1'b0, acc} - {1'b0, b};

  always_comb begin
    acc_nx = acc;
    acc_wr = 1'b1;
    case (op)
      OP_ADD:  acc_nx = sum[DATA_W-1:0];
      OP_SUB:  acc_nx = diff[DATA_W-1:0];
      OP_AND:  acc_nx = acc & b;
      OP_OR:   acc_nx = acc | b;
      OP_XOR:  acc_nx = acc ^ b;
      OP_NOT:  acc_nx = ~acc;
      OP_LDA:  acc_nx = mem[addr];
      default: acc_wr = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_HALT: if (start) state_nx = S_FETCH;
      S_FETCH:        state_nx = S_DECODE;
      S_DECODE:       state_nx = (op == OP_LDI || op == OP_LDB) ? S_IMM : S_EXEC;
      S_IMM:          state_nx = S_EXEC;
      S_EXEC:         state_nx = (op == OP_HLT) ? S_HALT : S_FETCH;
      default:        state_nx = S_IDLE;
    endcase
  end

  // Memory survives reset, but reset still blocks any write in its cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (load_ok)                            mem[load_addr] <= load_data;
      else if (state == S_EXEC && op == OP_STA) mem[addr]    <= acc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0; b <= '0; ir <= '0; pc <= '0;
      zf <= 1'b0; cf <= 1'b0; acc_out <= '0;
    end else begin
      case (state)
        S_IDLE, S_HALT: if (start) pc <= '0;
        S_FETCH: begin
          ir <= mem[pc];
          pc <= pc + 1'b1;
        end
        S_IMM: begin
          if (op == OP_LDB) b <= mem[pc];
          else begin
            acc <= mem[pc];
            zf  <= (mem[pc] == '0);
          end
          pc <= pc + 1'b1;
        end
        S_EXEC: begin
          if (acc_wr) begin
            acc <= acc_nx;
            zf  <= (acc_nx == '0);
          end
          if (op == OP_ADD) cf <= sum[DATA_W];
          if (op == OP_SUB) cf <= diff[DATA_W];
          if (op == OP_OUT) acc_out <= acc;
          if (op == OP_JMP || (op == OP_BEQ && zf) || (op == OP_BCS && cf))
            pc <= addr;
        end
        default: ;
      endcase
    end
  end

  assign pc_out     = pc;
  assign zero_flag  = zf;
  assign carry_flag = cf;
  assign busy       = !stopped;
  assign halted     = (state == S_HALT);

endmodule

// File: tb/tb_ultra_cpu_core.sv
// Bench for ultra_cpu_core: directed programs plus random programs checked
// against an instruction-level interpreter.
module tb_ultra_cpu_core;

  typedef int prog_t [16];

  logic       clk = 0, rst = 1, load_en = 0, run = 0;
  logic [3:0] load_addr = 0;
  logic [7:0] load_data = 0;
  logic [7:0] acc_out;
  logic [3:0] pc_out;
  logic       zero_flag, carry_flag, busy, halted;

  int n_chk = 0, n_err = 0;

  // interpreter state
  int mm [16];
  int m_acc, m_b, m_out, m_pc;
  bit m_z, m_c;

  ultra_cpu_core #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .run(run), .acc_out(acc_out), .pc_out(pc_out),
    .zero_flag(zero_flag), .carry_flag(carry_flag), .busy(busy), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    m_acc = 0; m_b = 0; m_out = 0; m_pc = 0; m_z = 0; m_c = 0;
  endtask

  task automatic model_run(output int cyc, output bit ok);
    int ir, op, a, v, s;
    m_pc = 0; cyc = 0; ok = 0;
    for (int n = 0; n < 300 && !ok; n++) begin
      ir = mm[m_pc]; m_pc = (m_pc + 1) % 16;
      op = ir / 16; a = ir % 16;
      if (op == 1 || op == 8) begin
        v = mm[m_pc]; m_pc = (m_pc + 1) % 16; cyc += 4;
        if (op == 1) begin m_acc = v; m_z = (v == 0); end
        else m_b = v;
      end else begin
        cyc += 3;
        case (op)
          2:  begin s = m_acc + m_b; m_c = (s > 255); m_acc = s % 256; end
          3:  begin m_c = (m_acc < m_b); m_acc = (m_acc - m_b + 256) % 256; end
          4:  m_acc = m_acc & m_b;
          5:  m_acc = m_acc | m_b;
          6:  m_acc = m_acc ^ m_b;
          7:  m_acc = 255 - m_acc;
          9:  mm[a] = m_acc;
          10: m_acc = mm[a];
          11: m_pc = a;
          12: if (m_z) m_pc = a;
          13: if (m_c) m_pc = a;
          14: m_out = m_acc;
          15: ok = 1;
          default: ;
        endcase
        if ((op >= 2 && op <= 7) || op == 10) m_z = (m_acc == 0);
      end
    end
  endtask

  task automatic do_reset();
    rst = 1; tick(); rst = 0;
    model_clear();
  endtask

  task automatic load_word(input int a, input int d);
    load_en = 1; load_addr = a[3:0]; load_data = d[7:0];
    tick();
    load_en = 0;
    mm[a] = d;
  endtask

  task automatic load_prog(input prog_t p);
    for (int w = 0; w < 16; w++) load_word(w, p[w]);
  endtask

  // Runs the model and the DUT; optional mid-run PC probe and busy-time load.
  task automatic run_check(input string tag, input int probe_at, input int probe_pc,
                           input int busy_load);
    int cyc, n;
    bit ok;
    model_run(cyc, ok);
    run = 1; tick(); run = 0;
    load_addr = 0; load_data = 8'h55;
    n = 0;
    while (!halted && n < cyc + 10) begin
      load_en = (n < busy_load);
      tick(); n++;
      if (n == probe_at) check({tag, "_probe_pc"}, pc_out, probe_pc);
    end
    load_en = 0;
    check({tag, "_cycles"}, n, cyc);
    check({tag, "_acc_out"}, acc_out, m_out);
    check({tag, "_pc"}, pc_out, m_pc);
    check({tag, "_z"}, zero_flag, m_z);
    check({tag, "_c"}, carry_flag, m_c);
    check({tag, "_halted"}, halted, 1);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    prog_t cand, sv_mm;
    int sv_acc, sv_b, sv_out, c;
    bit sv_z, sv_c, ok, found;

    tick(); tick();
    check("rst_acc_out", acc_out, 0);
    check("rst_pc", pc_out, 0);
    check("rst_flags", {zero_flag, carry_flag}, 0);
    check("rst_busy", busy, 0);
    check("rst_halted", halted, 0);
    rst = 0; model_clear();

    // LDA #5, LDB #3, ADD, OUT, HLT: 17 cycles
    load_prog('{'h10,'h05,'h80,'h03,'h20,'hE0,'hF0,0,0,0,0,0,0,0,0,0});
    run_check("tp1", -1, 0, 0);
    check("tp1_const_acc", acc_out, 8'h08);
    check("tp1_const_pc", pc_out, 7);

    // carry-out wraps to zero, BCS taken
    load_prog('{'h10,'hFF,'h80,'h01,'h20,'hD8,'hF0,0,'hE0,'hF0,0,0,0,0,0,0});
    run_check("bcs", -1, 0, 0);
    check("bcs_const", {acc_out, zero_flag, carry_flag, pc_out}, {8'h00, 1'b1, 1'b1, 4'hA});

    // borrow, BEQ not taken
    load_prog('{'h10,'h03,'h80,'h05,'h30,'hC8,'hE0,'hF0,'hF0,0,0,0,0,0,0,0});
    run_check("sub", -1, 0, 0);
    check("sub_const", {acc_out, zero_flag, carry_flag, pc_out}, {8'hFE, 1'b0, 1'b1, 4'h8});

    // JMP F; LDA # at F takes its immediate from address 0 after wrap
    load_prog('{'hBF,'hE0,'hF0,0,0,0,0,0,0,0,0,0,0,0,0,'h10});
    run_check("wrap", 6, 1, 0);
    check("wrap_const_acc", acc_out, 8'hBF);

    // load attempted while busy is dropped
    load_prog('{'hA0,'hE0,'hF0,0,0,0,0,0,0,0,0,0,0,0,0,0});
    run_check("busyload", -1, 0, 5);
    check("busyload_const", acc_out, 8'hA0);

    // load + run together in IDLE: write happens, core stays idle
    do_reset();
    load_en = 1; run = 1; load_addr = 3; load_data = 8'h77;
    tick();
    load_en = 0; run = 0; mm[3] = 'h77;
    tick();
    check("ldrun_busy", busy, 0);
    check("ldrun_halted", halted, 0);
    load_word(0, 'hA3); load_word(1, 'hE0); load_word(2, 'hF0);
    run_check("ldrun", -1, 0, 0);
    check("ldrun_const", acc_out, 8'h77);

    // reset during EXEC of STA 14 aborts the store
    do_reset();
    load_prog('{'hAE,'hE0,'h10,'h42,'h9E,'hF0,0,0,0,0,0,0,0,0,'h33,0});
    run = 1; tick(); run = 0;
    for (int i = 0; i < 12; i++) tick();
    rst = 1; tick(); rst = 0;
    model_clear();
    check("abort_outs", {acc_out, pc_out, zero_flag, carry_flag, busy, halted}, 0);
    run_check("replay", -1, 0, 0);
    check("replay_const", acc_out, 8'h33);
    run_check("replay2", -1, 0, 0);
    check("replay2_const", acc_out, 8'h42);

    // random programs; keep only ones the interpreter sees halt
    for (int it = 0; it < 40; it++) begin
      if (it % 3 == 0) do_reset();
      found = 0;
      for (int t = 0; t < 50 && !found; t++) begin
        for (int w = 0; w < 16; w++) cand[w] = int'($urandom_range(0, 255));
        sv_mm = mm; sv_acc = m_acc; sv_b = m_b; sv_out = m_out; sv_z = m_z; sv_c = m_c;
        mm = cand;
        model_run(c, ok);
        mm = sv_mm; m_acc = sv_acc; m_b = sv_b; m_out = sv_out; m_z = sv_z; m_c = sv_c;
        found = ok;
      end
      if (!found) cand[0] = 'hF0;
      load_prog(cand);
      run_check("rnd", -1, 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/ultra_cpu_core.md
# ultra_cpu_core

Parametrised accumulator CPU core: next generation of the tiny 8-bit accumulator CPU, generalised in data width and memory depth. It adds carry/zero flags, a carry branch, an explicit output latch, halt and a run/halt handshake. It sits behind the top-level pin wrapper, which maps dedicated inputs to load/run controls and drives `acc_out` to the output pins. Program memory is internal, written word-by-word while the core is stopped.

## Interface
- `DATA_W`, default 8: data, ACC, B and memory word width; must be >= 4 + `ADDR_W`.
- `ADDR_W`, default 4: address width; memory depth is 2**`ADDR_W` words.
- `clk` input 1: the single clock; all state changes on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `load_en` input 1: write `load_data` to `mem[load_addr]` this cycle (honoured only when not busy).
- `load_addr` input `ADDR_W`: program-load address.
- `load_data` input `DATA_W`: program-load word.
- `run` input 1: start execution at PC=0 (honoured only in IDLE or HALT).
- `acc_out` output `DATA_W`: output latch, written only by OUT.
- `pc_out` output `ADDR_W`: current PC.
- `zero_flag` output 1: Z flag.
- `carry_flag` output 1: C flag.
- `busy` output 1: high in FETCH/DECODE/IMM/EXEC.
- `halted` output 1: high in HALT.

## Operation
- Instruction word: opcode = bits [DATA_W-1:DATA_W-4]; operand addr = bits [ADDR_W-1:0]; other bits ignored.
- Opcodes:
  - 0 NOP; 1 LDA #imm (next word); 2 ADD B; 3 SUB B; 4 AND B; 5 OR B; 6 XOR B; 7 NOT ACC.
  - 8 LDB #imm; 9 STA addr; A LDA addr; B JMP addr.
  - C BEQ addr (taken if Z=1); D BCS addr (taken if C=1); E OUT (acc_out <= ACC); F HLT.
- Flags:
  - Z <= (new ACC == 0) on every ACC write (opcodes 1–7, A).
  - C written only by ADD (carry out of DATA_W-bit sum) and SUB (1 = borrow, i.e. ACC < B unsigned); all other opcodes keep C.
- Arithmetic is modulo 2**DATA_W.
- PC increments modulo 2**ADDR_W; wraps from 2**ADDR_W−1 to 0, including the immediate fetch.
- States:
  - IDLE: after reset. `run`=1 -> FETCH with PC<=0. ACC, B, flags and acc_out keep their values.
  - FETCH: IR <= mem[PC]; PC++ -> DECODE.
  - DECODE: opcode 1 or 8 -> IMM; else -> EXEC.
  - IMM: ACC (op 1, with Z update) or B (op 8) <= mem[PC]; PC++ -> EXEC.
  - EXEC: perform the opcode -> FETCH; HLT instead -> HALT.
  - HALT: `run`=1 -> FETCH with PC<=0, halted cleared.
- Loads:
  - `load_en` in IDLE/HALT writes memory.
  - `load_en` while busy is ignored; memory is unchanged.
  - If `load_en` and `run` are both asserted in IDLE/HALT, the load is performed and `run` is ignored that cycle.
- STA during execution writes memory in EXEC; a write to the currently fetched address is visible at the next FETCH.
- Reset:
  - ACC, B, IR, PC, Z, C, acc_out = 0; state IDLE; busy=0, halted=0.
  - Memory contents are not reset and are preserved across `rst`.
  - `rst` mid-instruction aborts it: no partial register or memory write from that cycle.

## Timing
- Cycle counts: 3 cycles for non-immediate instructions (FETCH, DECODE, EXEC); 4 cycles for opcodes 1 and 8.
- `run` sampled at edge k: state is FETCH after edge k, busy=1 from edge k.
- Result timing: ACC/flags/acc_out/PC effects of EXEC are visible after the EXEC edge; an IMM load is visible after the IMM edge.
- Branches and JMP: PC target is loaded at the EXEC edge, overriding the increment; not-taken leaves PC unchanged.
- HLT: halted=1 and busy=0 after the EXEC edge of HLT.
- Load: the memory write is visible to a FETCH on the following cycle.
- `rst` dominates `run` and `load_en` in the same cycle.

## Test plan
- Load mem0..6 = 10,05,80,03,20,E0,F0; pulse `run` at edge k -> exactly at edge k+17: halted=1, acc_out=0x08, Z=0, C=0, pc_out=7.
- Program LDA #FF, LDB #01, ADD, BCS 8; mem8 = E0, F0 -> ACC=0x00, Z=1, C=1, branch taken, acc_out=0x00, halted=1.
- SUB with ACC=0x03, B=0x05 -> ACC=0xFE, C=1, Z=0; BEQ not taken, PC falls through.
- JMP F with LDA #imm at address F (imm at addr 0 after wrap) -> PC wraps to 1 after IMM; ACC = mem0.
- `load_en` to addr 0 while busy -> mem0 unchanged on later readback via LDA 0 / OUT; `load_en`+`run` together in IDLE -> write done, core stays IDLE.
- Assert `rst` during the EXEC of STA -> target memory word unchanged, all outputs 0, IDLE; a second `run` replays the program with an identical result.
